// File: rtl/cpu_trace_pkg.sv
// Shared types and constants for the retire-trace checker.
package cpu_trace_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PASS, ST_FAIL} state_t;

  localparam int DEF_DATA_W      = 16;
  localparam int DEF_PC_W        = 16;
  localparam int DEF_DEPTH       = 64;
  localparam int DEF_TIMEOUT     = 250;
  localparam int DEF_HALT_REPEAT = 4;

  localparam int CYCLE_W = 16;
  localparam logic [CYCLE_W-1:0] CYCLE_MAX = '1;

  function automatic logic [CYCLE_W-1:0] cyc_inc(input logic [CYCLE_W-1:0] c);
    return (c == CYCLE_MAX) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/cpu_trace_checker_if.sv
// Table-load, retire-trace and status bundle of the trace checker.
// Entry width follows CPU_TRACE_CHECK_PC_EN (adds the expected pc above the alu field).
interface cpu_trace_checker_if #(
  parameter int DATA_W = cpu_trace_pkg::DEF_DATA_W,
  parameter int PC_W   = cpu_trace_pkg::DEF_PC_W,
  parameter int DEPTH  = cpu_trace_pkg::DEF_DEPTH
);
  localparam int AW = $clog2(DEPTH);
`ifdef CPU_TRACE_CHECK_PC_EN
  localparam int ENTRY_W = PC_W + DATA_W;
`else
  localparam int ENTRY_W = DATA_W;
`endif

  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [ENTRY_W-1:0] wr_data;
  logic [AW:0]        exp_len;
  logic               start;
  logic               retire;
  logic [PC_W-1:0]    pc_in;
  logic [DATA_W-1:0]  alu_in;
  logic               busy;
  logic               done;
  logic               pass;
  logic [AW:0]        err_count;
  logic [AW-1:0]      first_err_idx;
  logic [cpu_trace_pkg::CYCLE_W-1:0] cycle_count;

  modport master (
    output wr_en, wr_addr, wr_data, exp_len, start, retire, pc_in, alu_in,
    input  busy, done, pass, err_count, first_err_idx, cycle_count
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, exp_len, start, retire, pc_in, alu_in,
    output busy, done, pass, err_count, first_err_idx, cycle_count
  );
endinterface

// File: rtl/trace_expect_mem.sv
// Expected-result table: clocked write port, combinational read by run index.
module trace_expect_mem #(
  parameter int W     = 16,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/cpu_trace_checker.sv
// Retire-trace checker: compares each retired alu result against a preloaded table,
// flags PC self-loop halts and run timeouts. CPU_TRACE_CHECK_PC_EN adds pc compare.
module cpu_trace_checker
  import cpu_trace_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int PC_W        = DEF_PC_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int HALT_REPEAT = DEF_HALT_REPEAT
) (
  input logic               clk,
  input logic               reset,
  cpu_trace_checker_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(HALT_REPEAT + 1);
`ifdef CPU_TRACE_CHECK_PC_EN
  localparam int ENTRY_W = PC_W + DATA_W;
`else
  localparam int ENTRY_W = DATA_W;
`endif

  state_t             state;
  logic [AW:0]        idx, len_q, err_cnt, err_nxt;
  logic [AW-1:0]      first_idx;
  logic [CYCLE_W-1:0] cyc, cyc_nxt;
  logic [PC_W-1:0]    prev_pc;
  logic [HW-1:0]      hcnt, hcnt_nxt;
  logic [ENTRY_W-1:0] exp_entry;
  logic               tbl_we, miss, halt_hit, last_hit, tmo_hit;

  // Table is writable whenever no run is in flight.
  assign tbl_we = bus.wr_en && (state != ST_RUN);

  trace_expect_mem #(.W(ENTRY_W), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (tbl_we),
    .waddr (bus.wr_addr),
    .wdata (bus.wr_data),
    .raddr (idx[AW-1:0]),
    .rdata (exp_entry)
  );

  always_comb begin
`ifdef CPU_TRACE_CHECK_PC_EN
    miss = (exp_entry != {bus.pc_in, bus.alu_in});
`else
    miss = (exp_entry != bus.alu_in);
`endif
    // hcnt==0 means no retire yet this run, so there is no previous pc to match.
    hcnt_nxt = (hcnt != '0 && bus.pc_in == prev_pc) ? hcnt + 1'b1 : HW'(1);
    halt_hit = (hcnt_nxt == HW'(HALT_REPEAT));
    err_nxt  = (miss && err_cnt != '1) ? err_cnt + 1'b1 : err_cnt;
    last_hit = (idx == len_q - 1'b1);
    cyc_nxt  = cyc_inc(cyc);
    tmo_hit  = (cyc_nxt == CYCLE_W'(TIMEOUT));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      len_q     <= '0;
      err_cnt   <= '0;
      first_idx <= '0;
      cyc       <= '0;
      prev_pc   <= '0;
      hcnt      <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          cyc <= cyc_nxt;
          // A timeout edge ends the run outright; a retire landing on it is dropped.
          if (tmo_hit) state <= ST_FAIL;
          else if (bus.retire) begin
            idx     <= idx + 1'b1;
            prev_pc <= bus.pc_in;
            hcnt    <= hcnt_nxt;
            err_cnt <= err_nxt;
            if (err_cnt == '0 && (miss || halt_hit)) first_idx <= idx[AW-1:0];
            if (halt_hit)      state <= ST_FAIL;
            else if (last_hit) state <= (err_nxt == '0) ? ST_PASS : ST_FAIL;
          end
        end
        default: begin
          if (bus.start) begin
            len_q     <= (bus.exp_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.exp_len;
            idx       <= '0;
            err_cnt   <= '0;
            first_idx <= '0;
            cyc       <= '0;
            prev_pc   <= '0;
            hcnt      <= '0;
            state     <= (bus.exp_len == '0) ? ST_PASS : ST_RUN;
          end else if (bus.wr_en) begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy          = (state == ST_RUN);
  assign bus.done          = (state == ST_PASS) || (state == ST_FAIL);
  assign bus.pass          = (state == ST_PASS);
  assign bus.err_count     = err_cnt;
  assign bus.first_err_idx = first_idx;
  assign bus.cycle_count   = cyc;
endmodule

// File: tb/tb_cpu_trace_checker.sv
// Scoreboard bench for cpu_trace_checker: directed and random runs against a
// queue-level reference model; a monitor pops expectations when done rises.
module tb_cpu_trace_checker;
  localparam int DATA_W = 16, PC_W = 16, DEPTH = 16, TIMEOUT = 250, HALT_REPEAT = 4;
  localparam int AW = $clog2(DEPTH);

  typedef struct { bit pass; int errs; int first; int cyc; } res_t;

  logic clk = 0, rst_n = 0;
  int n_chk = 0, n_fail = 0;

  res_t exp_q[$];
  int ev_cyc[$];
  logic [PC_W-1:0]   ev_pc[$];
  logic [DATA_W-1:0] ev_alu[$];
  int err_after[$];
  int end_cyc;
  logic [DATA_W-1:0] m_alu [DEPTH];
  logic [PC_W-1:0]   m_pc  [DEPTH];

  cpu_trace_checker_if #(.DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH)) bus ();

  cpu_trace_checker #(.DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH),
                      .TIMEOUT(TIMEOUT), .HALT_REPEAT(HALT_REPEAT)) dut (
    .clk(clk), .reset(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic write_entry(input int a, input logic [PC_W-1:0] p, input logic [DATA_W-1:0] v);
    bus.wr_en = 1; bus.wr_addr = AW'(a);
`ifdef CPU_TRACE_CHECK_PC_EN
    bus.wr_data = {p, v};
`else
    bus.wr_data = v;
`endif
    m_pc[a] = p; m_alu[a] = v;
    step();
    bus.wr_en = 0;
  endtask

  task automatic ev_clear();
    ev_cyc.delete(); ev_pc.delete(); ev_alu.delete();
  endtask

  task automatic add_ev(input int c, input logic [PC_W-1:0] p, input logic [DATA_W-1:0] v);
    ev_cyc.push_back(c); ev_pc.push_back(p); ev_alu.push_back(v);
  endtask

  // Reference: walk the retire list in RUN-cycle order applying the run rules.
  task automatic model(input int len, output res_t r);
    int errs, first, streak;
    bit fin, bad;
    errs = 0; first = -1; streak = 0; fin = 0;
    r.pass = 0; r.cyc = TIMEOUT;
    err_after.delete();
    if (len == 0) begin
      r.pass = 1; r.errs = 0; r.first = 0; r.cyc = 0; end_cyc = 0;
      return;
    end
    foreach (ev_cyc[i]) begin
      if (fin || ev_cyc[i] >= TIMEOUT) break;
      bad = (ev_alu[i] != m_alu[i]);
`ifdef CPU_TRACE_CHECK_PC_EN
      bad = bad || (ev_pc[i] != m_pc[i]);
`endif
      streak = (i > 0 && ev_pc[i] == ev_pc[i-1]) ? streak + 1 : 1;
      if (bad) begin
        if (first < 0) first = i;
        errs++;
      end
      err_after.push_back(errs);
      if (streak >= HALT_REPEAT) begin
        if (first < 0) first = i;
        fin = 1; r.pass = 0; r.cyc = ev_cyc[i];
      end else if (i == len - 1) begin
        fin = 1; r.pass = (errs == 0); r.cyc = ev_cyc[i];
      end
    end
    r.errs = errs;
    r.first = (first < 0) ? 0 : first;
    end_cyc = r.cyc;
  endtask

  task automatic do_run(input int len, input bit ws, input bit noise);
    res_t r;
    int ei, last, a, w;
    bit rt;
    logic [PC_W-1:0] np;
    logic [DATA_W-1:0] na;
    if (bus.done) write_entry(0, m_pc[0], m_alu[0]);
    if (ws) begin
      a = $urandom_range(0, DEPTH-1);
      np = PC_W'($urandom); na = DATA_W'($urandom);
      bus.wr_en = 1; bus.wr_addr = AW'(a);
`ifdef CPU_TRACE_CHECK_PC_EN
      bus.wr_data = {np, na};
`else
      bus.wr_data = na;
`endif
      m_pc[a] = np; m_alu[a] = na;
    end
    model(len, r);
    exp_q.push_back(r);
    bus.exp_len = (AW+1)'(len); bus.start = 1;
    step();
    bus.start = 0; bus.wr_en = 0;
    ei = 0;
    last = (ev_cyc.size() > 0) ? ev_cyc[ev_cyc.size()-1] : 0;
    for (int k = 1; k <= last; k++) begin
      rt = 0;
      if (ei < ev_cyc.size() && ev_cyc[ei] == k) begin
        bus.retire = 1; bus.pc_in = ev_pc[ei]; bus.alu_in = ev_alu[ei]; ei++; rt = 1;
      end
      if (noise && k <= end_cyc) begin
        bus.wr_en = ($urandom_range(0, 3) == 0);
        bus.wr_addr = AW'($urandom); bus.wr_data = '1;
        bus.start = ($urandom_range(0, 7) == 0);
        bus.exp_len = (AW+1)'($urandom_range(0, DEPTH));
      end
      step();
      bus.retire = 0; bus.wr_en = 0; bus.start = 0;
      if (rt && ei - 1 < err_after.size())
        chk("err_count_after_retire", int'(bus.err_count), err_after[ei-1]);
    end
    w = 0;
    while (!bus.done && w < 400) begin step(); w++; end
    if (!bus.done) chk("done_within_bound", 0, 1);
    step();
  endtask

  task automatic load_all();
    logic [PC_W-1:0] base;
    base = PC_W'($urandom_range(0, 16'h7000));
    for (int a = 0; a < DEPTH; a++) write_entry(a, base + PC_W'(2*a), DATA_W'($urandom));
  endtask

  task automatic gen_rand(input int len, input int maxgap, input bit halty, input int err_pct);
    int c, n;
    bit good;
    logic [PC_W-1:0] p;
    ev_clear();
    c = 0; p = PC_W'($urandom_range(0, 16'h7000));
    n = len + int'($urandom_range(0, 2));
    for (int i = 0; i < n; i++) begin
      c += 1 + int'($urandom_range(0, maxgap));
      if (!(halty && i > 0 && $urandom_range(0, 1) == 1)) p = p + PC_W'(2);
      good = (i < len) && (int'($urandom_range(0, 99)) >= err_pct);
`ifdef CPU_TRACE_CHECK_PC_EN
      if (good) p = m_pc[i];
`endif
      add_ev(c, p, good ? m_alu[i] : DATA_W'($urandom));
    end
  endtask

  // Monitor: one expectation per rising done.
  initial begin
    bit dprev;
    res_t e;
    dprev = 0;
    forever begin
      @(negedge clk);
      if (bus.done && !dprev) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("pass", int'(bus.pass), int'(e.pass));
          chk("err_count", int'(bus.err_count), e.errs);
          chk("first_err_idx", int'(bus.first_err_idx), e.first);
          chk("cycle_count", int'(bus.cycle_count), e.cyc);
          chk("busy_at_done", int'(bus.busy), 0);
        end
      end
      dprev = bus.done;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.exp_len = '0;
    bus.start = 0; bus.retire = 0; bus.pc_in = '0; bus.alu_in = '0;
    repeat (3) step();
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_pass", int'(bus.pass), 0);
    chk("rst_err_count", int'(bus.err_count), 0);
    chk("rst_first_err_idx", int'(bus.first_err_idx), 0);
    chk("rst_cycle_count", int'(bus.cycle_count), 0);
    rst_n = 1;
    step();

    // Matching run with gaps between retires.
    write_entry(0, 16'h0100, 16'h0005);
    write_entry(1, 16'h0102, 16'h000A);
    write_entry(2, 16'h0104, 16'h0003);
    ev_clear(); add_ev(2, 16'h0100, 16'h0005); add_ev(4, 16'h0102, 16'h000A); add_ev(7, 16'h0104, 16'h0003);
    do_run(3, 0, 0);

    // Second and third retire mismatch.
    ev_clear(); add_ev(1, 16'h0100, 16'h0005); add_ev(3, 16'h0102, 16'h000B); add_ev(5, 16'h0104, 16'h0007);
    do_run(3, 0, 0);

    // Reset mid-run after two retires, then a clean restart on the same table.
    write_entry(0, 16'h0100, 16'h0005);
    bus.exp_len = 3; bus.start = 1; step(); bus.start = 0;
    bus.retire = 1; bus.pc_in = 16'h0100; bus.alu_in = 16'h0005; step();
    bus.pc_in = 16'h0102; bus.alu_in = 16'h000A; step();
    bus.retire = 0;
    #2 rst_n = 0;
    #1;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_done", int'(bus.done), 0);
    chk("midrst_pass", int'(bus.pass), 0);
    chk("midrst_err_count", int'(bus.err_count), 0);
    chk("midrst_cycle_count", int'(bus.cycle_count), 0);
    step(); rst_n = 1; step();
    ev_clear(); add_ev(1, 16'h0100, 16'h0005); add_ev(2, 16'h0102, 16'h000A); add_ev(4, 16'h0104, 16'h0003);
    do_run(3, 0, 0);

    // Halt: same pc on four retires with matching data.
    for (int a = 0; a < 4; a++) write_entry(a, 16'h0010, DATA_W'(16'h0021 + a));
    ev_clear();
    for (int i = 0; i < 4; i++) add_ev(i + 1, 16'h0010, DATA_W'(16'h0021 + i));
    do_run(4, 0, 0);

    // Timeout with no retires.
    ev_clear();
    do_run(3, 0, 0);

    // Zero-length run, and write+start in the same cycle.
    ev_clear();
    do_run(0, 0, 0);
    ev_clear(); add_ev(1, 16'h0010, 16'h0021);
    do_run(1, 1, 0);

`ifdef CPU_TRACE_CHECK_PC_EN
    write_entry(0, 16'h0002, 16'h0005);
    ev_clear(); add_ev(1, 16'h0004, 16'h0005);
    do_run(1, 0, 0);
`endif

    for (int t = 0; t < 30; t++) begin
      int len;
      len = $urandom_range(0, DEPTH);
      load_all();
      gen_rand(len, ($urandom_range(0, 3) == 0) ? 30 : 3, ($urandom_range(0, 2) == 0),
               int'($urandom_range(0, 30)));
      do_run(len, ($urandom_range(0, 3) == 0), 1);
    end

    repeat (2) step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_trace_checker.md
Name: cpu_trace_checker

Overview:
- Synthesizable run monitor for MIPS16-class cores. It replaces the open-loop "reset, wait, finish" bench flow with a self-checking one.
- Holds a table of expected ALU results that is loaded before a run. Each retire strobe's alu_result is compared against the next table entry.
- Also detects PC halt (self-loop) and cycle timeout. Reports pass/fail, error count and first failing index.
- Sits beside the core in the testbench top, or on-chip behind a debug port. Generalised in data width, table depth and timeout.

Parameters:
- DATA_W, 16, width of alu_result and expected entries
- PC_W, 16, width of pc_out
- DEPTH, 64, expected-table entries (power of two, >=2)
- TIMEOUT, 250, max cycles in RUN before forced FAIL
- HALT_REPEAT, 4, consecutive retires with identical PC that declare halt

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- wr_en  in  1  table write strobe; accepted only in IDLE
- wr_addr  in  $clog2(DEPTH)  table write address
- wr_data  in  DATA_W  expected alu_result
- exp_len  in  $clog2(DEPTH)+1  number of valid entries, sampled on start
- start  in  1  begin run; accepted only in IDLE
- retire  in  1  one instruction retired this cycle
- pc_in  in  PC_W  core pc_out
- alu_in  in  DATA_W  core alu_result
- busy  out  1  high in RUN
- done  out  1  high in PASS or FAIL
- pass  out  1  high only in PASS
- err_count  out  $clog2(DEPTH)+1  mismatches seen, saturating
- first_err_idx  out  $clog2(DEPTH)  index of first mismatch
- cycle_count  out  16  cycles spent in RUN, saturating at 16'hFFFF

Behaviour:
- Reset (reset=0, async): state IDLE. busy, done, pass = 0. err_count, first_err_idx, cycle_count, index and halt counter = 0. Table contents are not reset.
- FSM states: IDLE, RUN, PASS, FAIL.
  - IDLE: wr_en writes table[wr_addr] on the clock edge. start latches exp_len, clears all counters and moves to RUN the next cycle. start with exp_len=0 goes directly to PASS. wr_en and start in the same cycle: the write completes; start is honoured.
  - RUN: each retire cycle compares alu_in with table[idx] and increments idx.
    - On mismatch, err_count increments, saturating at its maximum.
    - first_err_idx captures idx only on the first mismatch.
    - The compare result is registered; err_count updates 1 cycle after the retire.
    - The table read is combinational or 1-cycle; implementer's choice. The result is observable at err_count exactly 1 cycle after retire.
  - RUN exit: on the cycle the final compare (idx = exp_len-1) registers, go to PASS if err_count=0, else FAIL.
  - Halt: if pc_in equals the previous retired pc for HALT_REPEAT consecutive retires while idx<exp_len, go to FAIL. first_err_idx = idx if no earlier error.
  - Timeout: cycle_count reaching TIMEOUT in RUN goes to FAIL. Timeout has priority over same-cycle completion.
  - RUN ignores wr_en and start.
  - PASS/FAIL: outputs hold. start re-arms, as from IDLE, using the existing table. A wr_en first returns the FSM to IDLE and performs the write.
- retire is ignored outside RUN.
- The table index never wraps within a run: idx stops at exp_len.
- Asynchronous reset mid-RUN aborts immediately to IDLE; no done pulse.

Optional Feature:
- Macro: CPU_TRACE_CHECK_PC_EN.
- Defined: each table entry widens to {PC_W expected pc, DATA_W expected alu}, and wr_data widens to PC_W+DATA_W. A retire mismatches if either field differs.
- Undefined: alu-only compare, table width DATA_W, no PC storage.

Decomposition:
- Shared package cpu_trace_pkg:
  - state enum (IDLE/RUN/PASS/FAIL)
  - default widths
  - CYCLE_W=16 and the saturation constant
- One natural sub-module: trace_expect_mem, a simple dual-port table with write in IDLE and read by idx. This isolates the feature-dependent entry width.

Test Plan:
- Load table {0x0005,0x000A,0x0003}, exp_len=3, start, then retire with matching alu values on 3 non-consecutive cycles -> PASS, pass=1, err_count=0, cycle_count equal to cycles elapsed.
- Same table, second retire alu=0x000B -> FAIL, err_count=1, first_err_idx=1. A later third mismatch gives err_count=2 and first_err_idx still 1.
- exp_len=4, pc_in held at 0x0010 for 4 retires with matching alu -> FAIL via halt; first_err_idx=3 if the 4th retire halts before any error.
- TIMEOUT=250, start, no retire for 250 cycles -> FAIL at cycle_count=250, busy low the following cycle.
- Drop reset mid-RUN after 2 retires -> all outputs 0, state IDLE. A restart with unchanged table and exp_len=3 passes with fresh counters.
- With CPU_TRACE_CHECK_PC_EN: entry {0x0002,0x0005}, retire pc=0x0004 alu=0x0005 -> err_count=1, FAIL.
